// File: rtl/operation_driver.sv
// operation_driver: initiator for the start/ready operation-unit protocol.
// Takes an operand pair over a valid/ready handshake and keeps the unit in
// reset while idle. It gives the unit one clear cycle out of reset, then
// raises ST and waits for RD under a cycle timeout. The captured result,
// error flag and cycle count leave over a valid/ready handshake.
module operation_driver #(
  parameter int BW         = 16,
  parameter int TMO_CYCLES = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [BW-1:0] IN_A,
  input  logic [BW-1:0] IN_B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [BW-1:0] OUT_RES,
  output logic          OUT_ERR,
  output logic [15:0]   OUT_CYC,
  output logic          OP_RST,
  output logic          OP_ST,
  output logic [BW-1:0] OP_IN0,
  output logic [BW-1:0] OP_IN1,
  input  logic          OP_RD,
  input  logic [BW-1:0] OP_RES
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] TMO = 16'(TMO_CYCLES);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        accept;
  logic        rd_hit;
  logic        tmo_hit;
  logic        finish;

  // RD takes priority over the timeout when both land on the same edge.
  assign accept  = (state == IDLE) && IN_VALID;
  assign rd_hit  = (state == RUN) && OP_RD;
  assign tmo_hit = (state == RUN) && !OP_RD && (cnt == TMO);
  assign finish  = rd_hit || tmo_hit;

  // Sequencer: state, RUN cycle counter, handshakes and unit control lines.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      OP_RST    <= 1'b1;
      OP_ST     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            IN_READY <= 1'b0;
            OP_RST   <= 1'b0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          OP_ST <= 1'b1;
          cnt   <= 16'd1;
          state <= RUN;
        end
        RUN: begin
          if (finish) begin
            OUT_VALID <= 1'b1;
            OP_ST     <= 1'b0;
            OP_RST    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Operands are latched on accept and held until the next accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OP_IN0 <= '0;
      OP_IN1 <= '0;
    end else if (accept) begin
      OP_IN0 <= IN_A;
      OP_IN1 <= IN_B;
    end
  end

  // Result capture on completion; OP_RES is only looked at on the RD edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_RES <= '0;
      OUT_ERR <= 1'b0;
      OUT_CYC <= '0;
    end else if (finish) begin
      OUT_RES <= rd_hit ? OP_RES : '0;
      OUT_ERR <= !rd_hit;
      OUT_CYC <= cnt;
    end
  end

endmodule

// File: tb/tb_operation_driver.sv
// Bench for operation_driver with a behavioural operation unit that raises
// RD on a chosen RUN edge. Expected results are queued on stimulus and
// compared when the driver presents them.
module tb_operation_driver;

  localparam int BW  = 16;
  localparam int TMO = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [BW-1:0] IN_A;
  logic [BW-1:0] IN_B;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [BW-1:0] OUT_RES;
  logic          OUT_ERR;
  logic [15:0]   OUT_CYC;
  logic          OP_RST;
  logic          OP_ST;
  logic [BW-1:0] OP_IN0;
  logic [BW-1:0] OP_IN1;
  logic          OP_RD;
  logic [BW-1:0] OP_RES;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int            rd_at    = 0;
  logic [BW-1:0] unit_res = '0;
  int            runcnt   = 0;

  operation_driver #(.BW(BW), .TMO_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RES(OUT_RES),
    .OUT_ERR(OUT_ERR), .OUT_CYC(OUT_CYC),
    .OP_RST(OP_RST), .OP_ST(OP_ST), .OP_IN0(OP_IN0), .OP_IN1(OP_IN1),
    .OP_RD(OP_RD), .OP_RES(OP_RES)
  );

  always #5 CLK = ~CLK;

  // Behavioural unit: counts RUN edges, RD high on edge number rd_at.
  always @(posedge CLK) runcnt <= OP_ST ? runcnt + 1 : 0;
  assign OP_RD  = OP_ST && (rd_at != 0) && (runcnt == rd_at - 1);
  assign OP_RES = OP_RD ? unit_res : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int rd, input logic [BW-1:0] res);
    exp_t e;
    if (rd != 0 && rd <= TMO) begin
      e.res = res; e.err = 1'b0; e.cyc = 16'(rd);
    end else begin
      e.res = '0;  e.err = 1'b1; e.cyc = 16'(TMO);
    end
    sb.push_back(e);
  endtask

  task automatic wait_in_ready();
    int k = 0;
    while (!IN_READY && k < 50) begin @(negedge CLK); k++; end
    if (!IN_READY) chk("in_ready_wait", 32'(IN_READY), 32'd1);
  endtask

  task automatic wait_out();
    int k = 0;
    while (!OUT_VALID && k < 200) begin @(negedge CLK); k++; end
    if (!OUT_VALID) chk("out_valid_wait", 32'(OUT_VALID), 32'd1);
  endtask

  task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input int rd, input logic [BW-1:0] res);
    wait_in_ready();
    IN_A = a; IN_B = b; IN_VALID = 1'b1;
    rd_at = rd; unit_res = res;
    push_exp(rd, res);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("clr_in0",   32'(OP_IN0),   32'(a));
    chk("clr_in1",   32'(OP_IN1),   32'(b));
    chk("clr_rst",   32'(OP_RST),   32'd0);
    chk("clr_st",    32'(OP_ST),    32'd0);
    chk("clr_ready", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    chk("run_st",  32'(OP_ST),  32'd1);
    chk("run_rst", 32'(OP_RST), 32'd0);
  endtask

  task automatic compare_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_res", 32'(OUT_RES), 32'(e.res));
      chk("out_err", 32'(OUT_ERR), 32'(e.err));
      chk("out_cyc", 32'(OUT_CYC), 32'(e.cyc));
    end
  endtask

  task automatic finish_op(input logic [BW-1:0] a, input logic [BW-1:0] b);
    wait_out();
    chk("done_st",  32'(OP_ST),  32'd0);
    chk("done_rst", 32'(OP_RST), 32'd1);
    chk("done_in0", 32'(OP_IN0), 32'(a));
    chk("done_in1", 32'(OP_IN1), 32'(b));
    compare_result();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk("idle_valid", 32'(OUT_VALID), 32'd0);
    chk("idle_ready", 32'(IN_READY),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; OUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 32'(IN_READY),  32'd1);
    chk("rst_out_vld",  32'(OUT_VALID), 32'd0);
    chk("rst_op_rst",   32'(OP_RST),    32'd1);
    chk("rst_op_st",    32'(OP_ST),     32'd0);
    chk("rst_out_res",  32'(OUT_RES),   32'd0);
    chk("rst_out_err",  32'(OUT_ERR),   32'd0);
    chk("rst_out_cyc",  32'(OUT_CYC),   32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_in_ready", 32'(IN_READY),  32'd1);
    chk("post_out_vld",  32'(OUT_VALID), 32'd0);
    chk("post_op_rst",   32'(OP_RST),    32'd1);
    chk("post_op_st",    32'(OP_ST),     32'd0);
    chk("post_out_cyc",  32'(OUT_CYC),   32'd0);

    // Nominal: RD on the third RUN edge
    start_op(16'h0000, 16'h0001, 3, 16'h0005);
    finish_op(16'h0000, 16'h0001);

    // Minimum latency: RD on the first RUN edge
    start_op(16'h1111, 16'h2222, 1, 16'h3333);
    finish_op(16'h1111, 16'h2222);

    // Timeout: RD never raised
    start_op(16'hA5A5, 16'h5A5A, 0, 16'h0000);
    finish_op(16'hA5A5, 16'h5A5A);

    // Race: RD exactly on the timeout edge
    start_op(16'h00F0, 16'h000F, TMO, 16'hBEEF);
    finish_op(16'h00F0, 16'h000F);

    // Backpressure with new operands waiting
    start_op(16'h1234, 16'h5678, 2, 16'h00AA);
    wait_out();
    IN_A = 16'h9999; IN_B = 16'h7777; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_valid", 32'(OUT_VALID), 32'd1);
      chk("stall_res",   32'(OUT_RES),   32'h00AA);
      chk("stall_cyc",   32'(OUT_CYC),   32'd2);
      chk("stall_ready", 32'(IN_READY),  32'd0);
      chk("stall_in0",   32'(OP_IN0),    32'h1234);
      chk("stall_in1",   32'(OP_IN1),    32'h5678);
      chk("stall_st",    32'(OP_ST),     32'd0);
    end
    compare_result();
    OUT_READY = 1'b1;
    rd_at = 4; unit_res = 16'h4242;
    push_exp(4, 16'h4242);
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk("b2b_idle_valid", 32'(OUT_VALID), 32'd0);
    chk("b2b_idle_ready", 32'(IN_READY),  32'd1);
    chk("b2b_idle_in0",   32'(OP_IN0),    32'h1234);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("b2b_in0",   32'(OP_IN0),   32'h9999);
    chk("b2b_in1",   32'(OP_IN1),   32'h7777);
    chk("b2b_ready", 32'(IN_READY), 32'd0);
    finish_op(16'h9999, 16'h7777);

    // Reset two cycles into RUN aborts the operation
    start_op(16'h0F0F, 16'hF0F0, 0, 16'h0000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_st",    32'(OP_ST),     32'd0);
    chk("abort_rst",   32'(OP_RST),    32'd1);
    chk("abort_ready", 32'(IN_READY),  32'd1);
    chk("abort_valid", 32'(OUT_VALID), 32'd0);
    if (sb.size() != 0) void'(sb.pop_back());
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_post_valid", 32'(OUT_VALID), 32'd0);
    chk("abort_post_ready", 32'(IN_READY),  32'd1);
    chk("abort_post_in0",   32'(OP_IN0),    32'd0);

    // Recovery after abort
    start_op(16'hCAFE, 16'h0042, 5, 16'h7E57);
    finish_op(16'hCAFE, 16'h0042);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operation_driver.md
Name: operation_driver

Overview:
- Initiator side of the start/ready operation-unit protocol (RST/ST/CLK/RD/RES/IN0/IN1) used by the Maltsev operation blocks.
- Accepts an operand pair over a valid/ready handshake and holds the downstream unit in reset while idle.
- Releases reset for one cycle, then raises ST and waits for RD, with a timeout.
- Captures RES and presents result, error flag and cycle count over a valid/ready output handshake.

Parameters:
BW, 16, operand/result bit width
TMO_CYCLES, 1024, maximum RUN cycles before timeout; legal range 2..65535

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
IN_VALID  input  1  operand pair valid
IN_READY  output  1  driver can accept operands
IN_A  input  BW  first operand
IN_B  input  BW  second operand
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
OUT_RES  output  BW  captured result (0 on timeout)
OUT_ERR  output  1  1 = timeout, no RD seen
OUT_CYC  output  16  RUN cycles consumed
OP_RST  output  1  active-high reset to operation unit
OP_ST  output  1  start to operation unit
OP_IN0  output  BW  operand 0 to unit
OP_IN1  output  BW  operand 1 to unit
OP_RD  input  1  unit ready/result valid
OP_RES  input  BW  unit result

Behaviour:
- All outputs are registered. RST low asynchronously forces the following, regardless of state:
  - state IDLE, IN_READY=1, OUT_VALID=0
  - OUT_RES=0, OUT_ERR=0, OUT_CYC=0
  - OP_RST=1, OP_ST=0, OP_IN0=0, OP_IN1=0, cnt=0
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - IN_READY=1, OP_RST=1, OP_ST=0.
  - An edge with IN_VALID=1 latches IN_A->OP_IN0 and IN_B->OP_IN1, sets IN_READY=0 and OP_RST=0, and moves to CLEAR.
- CLEAR:
  - Lasts exactly one cycle with OP_RST=0, OP_ST=0.
  - Next edge: OP_ST=1, cnt=1, move to RUN.
- RUN: OP_ST=1, and OP_RD is sampled each edge.
  - OP_RD=1: OUT_RES=OP_RES, OUT_ERR=0, OUT_CYC=cnt, OUT_VALID=1, OP_ST=0, OP_RST=1, move to DONE.
  - Else if cnt==TMO_CYCLES: OUT_RES=0, OUT_ERR=1, OUT_CYC=cnt, OUT_VALID=1, OP_ST=0, OP_RST=1, move to DONE.
  - Else: cnt=cnt+1.
  - RD and timeout on the same edge: RD wins, ERR=0.
- Minimum latency from accept edge to OUT_VALID is 3 edges, giving OUT_CYC=1.
- DONE:
  - OUT_VALID and OUT_* are held stable; OP_RST=1, OP_ST=0; IN_VALID is ignored.
  - An edge with OUT_READY=1 sets OUT_VALID=0, IN_READY=1 and moves to IDLE.
  - There is no accept in the same cycle as result delivery.
- OP_RD is ignored outside RUN. OP_RES is sampled only on the RD edge.
- OP_IN0/OP_IN1 stay constant from accept until the next accept.
- Reset mid-operation aborts with no result delivered. The unit is returned to reset immediately because OP_RST's reset value is 1.
- cnt is 16-bit; TMO_CYCLES ≤ 65535, so no wrap.

Test Plan:
- Reset: hold RST=0 over several edges -> IN_READY=1, OUT_VALID=0, OP_RST=1, OP_ST=0, OUT_RES=0, OUT_ERR=0, OUT_CYC=0, checked also after RST rises.
- Nominal op: IN_A=0, IN_B=1 accepted; behavioural unit raises RD on the 3rd RUN edge with RES=16'h0005.
  - OP_IN0=0, OP_IN1=1; OP_RST falls one edge before OP_ST rises.
  - OUT_VALID=1, OUT_RES=16'h0005, OUT_ERR=0, OUT_CYC=3; OP_ST=0 and OP_RST=1 on the same edge.
- Timeout: TMO_CYCLES=8, RD never asserted -> after 8 RUN edges OUT_VALID=1, OUT_ERR=1, OUT_RES=0, OUT_CYC=8, OP_ST=0.
- Race: TMO_CYCLES=8, RD=1 with RES=16'hBEEF exactly on the 8th RUN edge -> OUT_ERR=0, OUT_RES=16'hBEEF, OUT_CYC=8.
- Backpressure/back-to-back: OUT_READY=0 for 5 cycles while IN_VALID=1 with new operands.
  - During the stall: outputs stable, IN_READY=0, OP_IN0/1 unchanged.
  - OUT_READY=1 -> IDLE; next edge accepts new operands and the second result is correct.
- Reset mid-RUN: drive RST=0 two cycles into RUN -> OP_ST=0 and OP_RST=1 immediately. After release, OUT_VALID stays 0 and IN_READY=1.
